uart_rx_device: RTL and testbench

Memory-mapped 8N1 UART receiver on the SoC device bus, alongside the existing transmit path (`tx`). It samples the board's `rx` pin, deframes bytes into a small receive FIFO, and exposes data, status and control registers. The CPU reaches these registers through the same non-delayed `valid`/`addr`/`wdata`/`wvalid`/`rdata` access used by the other device registers. Reads have no side effects; bytes are consumed by an explicit pop write.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_rx_fifo.sv | 49 ++++
 rtl/uart_rx_device.sv | 207 ++++++++++++++++++++
 tb/tb_uart_rx_device.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and register map for the UART receive path.
// Build option UART_RX_FIFO_EN selects the multi-entry receive FIFO.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_e;

    localparam logic [1:0] UART_RXDATA = 2'd0;
    localparam logic [1:0] UART_STATUS = 2'd1;
    localparam logic [1:0] UART_CTRL   = 2'd2;

    localparam int ST_NOT_EMPTY = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_OVERRUN   = 2;
    localparam int ST_FRAME_ERR = 3;
    localparam int ST_COUNT     = 8;

endpackage

// File: rtl/uart_rx_fifo.sv
// Circular receive FIFO; a push and pop may share a cycle even when full.
// Only instantiated when UART_RX_FIFO_EN is defined.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [7:0]    din,
    output logic [7:0]    dout,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 8'h00;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign dout  = mem[rd_ptr];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/uart_rx_device.sv
// Memory-mapped 8N1 UART receiver with RXDATA/STATUS/CTRL registers.
// Define UART_RX_FIFO_EN for a FIFO_DEPTH-entry queue; otherwise one holding register.
module uart_rx_device
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx,
    input  logic        valid,
    input  logic [63:0] addr,
    input  logic        wvalid,
    input  logic [63:0] wdata,
    output logic [63:0] rdata,
    output logic        irq
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

    logic            sync1;
    logic            rx_s;
    logic [1:0]      fill;
    logic            armed;

    rx_state_e       state;
    rx_state_e       state_n;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_n;
    logic [2:0]      idx;
    logic [2:0]      idx_n;
    logic [7:0]      shreg;
    logic [7:0]      shreg_n;
    logic            push_req;
    logic            ferr_set;

    logic            ctrl_wr;
    logic            pop;
    logic            clr;
    logic            push_ok;
    logic            ovr_set;
    logic            not_empty;
    logic            full;
    logic [7:0]      head;
    logic [3:0]      count;
    logic            overrun;
    logic            frame_err;
    logic            unused_bits;

    // fill marks when rx_s carries a real pin sample rather than its reset value
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= 1'b1;
            rx_s  <= 1'b1;
            fill  <= 2'b00;
            armed <= 1'b0;
        end else begin
            sync1 <= rx;
            rx_s  <= sync1;
            fill  <= {fill[0], 1'b1};
            armed <= armed | (fill[1] & rx_s);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            shreg <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            idx   <= idx_n;
            shreg <= shreg_n;
        end
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt + 1'b1;
        idx_n    = idx;
        shreg_n  = shreg;
        push_req = 1'b0;
        ferr_set = 1'b0;
        unique case (state)
            IDLE: begin
                cnt_n = '0;
                if (armed && !rx_s) begin
                    state_n = START;
                end
            end
            START: begin
                if (cnt == HALF_M1) begin
                    cnt_n   = '0;
                    idx_n   = '0;
                    state_n = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == FULL_M1) begin
                    cnt_n   = '0;
                    shreg_n = {rx_s, shreg[7:1]};
                    idx_n   = idx + 1'b1;
                    if (idx == 3'd7) begin
                        state_n = STOP;
                    end
                end
            end
            STOP: begin
                if (cnt == FULL_M1) begin
                    cnt_n    = '0;
                    state_n  = IDLE;
                    push_req = rx_s;
                    ferr_set = !rx_s;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign ctrl_wr = valid & wvalid & (addr[4:3] == UART_CTRL);
    assign pop     = ctrl_wr & wdata[0] & not_empty;
    assign clr     = ctrl_wr & wdata[1];
    assign push_ok = push_req & (~full | pop);
    assign ovr_set = push_req & full & ~pop;

`ifdef UART_RX_FIFO_EN
    localparam int FCW = $clog2(FIFO_DEPTH) + 1;
    logic [FCW-1:0] fifo_count;
    logic           fifo_empty;

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_ok),
        .pop   (pop),
        .din   (shreg),
        .dout  (head),
        .full  (full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign not_empty = ~fifo_empty;
    assign count     = 4'(fifo_count);
`else
    logic       hold_valid;
    logic [7:0] hold_data;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_valid <= 1'b0;
            hold_data  <= 8'h00;
        end else if (push_ok) begin
            hold_valid <= 1'b1;
            hold_data  <= shreg;
        end else if (pop) begin
            hold_valid <= 1'b0;
        end
    end

    assign not_empty = hold_valid;
    assign full      = hold_valid;
    assign head      = hold_data;
    assign count     = {3'b000, hold_valid};
`endif

    // a flag set in the same cycle as a clear takes priority
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            overrun   <= ovr_set | (overrun & ~clr);
            frame_err <= ferr_set | (frame_err & ~clr);
        end
    end

    always_comb begin
        rdata = '0;
        unique case (addr[4:3])
            UART_RXDATA: begin
                rdata[7:0] = not_empty ? head : 8'h00;
            end
            UART_STATUS: begin
                rdata[ST_NOT_EMPTY]     = not_empty;
                rdata[ST_FULL]          = full;
                rdata[ST_OVERRUN]       = overrun;
                rdata[ST_FRAME_ERR]     = frame_err;
                rdata[ST_COUNT +: 4]    = count;
            end
            default: rdata = '0;
        endcase
    end

    assign irq = not_empty;

    assign unused_bits = ^{addr[63:5], addr[2:0], wdata[63:2],
                           FIFO_DEPTH != 0};

endmodule

// File: tb/tb_uart_rx_device.sv
// Randomized frame bench for uart_rx_device against a queue-based model.
// The model depth follows UART_RX_FIFO_EN like the design.
module tb_uart_rx_device;

    localparam int CPB   = 16;
    localparam int DEPTH = 4;
`ifdef UART_RX_FIFO_EN
    localparam int MDEPTH = DEPTH;
`else
    localparam int MDEPTH = 1;
`endif
    localparam int LAT = 2 + CPB / 2 + 9 * CPB;

    localparam logic [63:0] A_DATA = 64'd0;
    localparam logic [63:0] A_STAT = 64'd8;
    localparam logic [63:0] A_CTRL = 64'd16;
    localparam logic [63:0] A_RSVD = 64'd24;

    logic        clk = 1'b0;
    logic        reset;
    logic        rx;
    logic        valid;
    logic        wvalid;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] rdata;
    logic        irq;

    int total = 0;
    int bad   = 0;

    logic [7:0] mq[$];
    bit         m_ovr;
    bit         m_ferr;

    uart_rx_device #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .rx     (rx),
        .valid  (valid),
        .addr   (addr),
        .wvalid (wvalid),
        .wdata  (wdata),
        .rdata  (rdata),
        .irq    (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic rd(input logic [63:0] a, output logic [63:0] d);
        addr   = a;
        valid  = 1'b1;
        wvalid = 1'b0;
        #1;
        d      = rdata;
        valid  = 1'b0;
    endtask

    task automatic wr(input logic [63:0] a, input logic [63:0] d);
        addr   = a;
        wdata  = d;
        valid  = 1'b1;
        wvalid = 1'b1;
        @(posedge clk);
        #1;
        valid  = 1'b0;
        wvalid = 1'b0;
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop_ok);
        rx = 1'b0;
        cycles(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            cycles(CPB);
        end
        rx = stop_ok;
        cycles(CPB);
        rx = 1'b1;
    endtask

    function automatic void model_frame(input logic [7:0] b, input bit ok,
                                        input bit pop_same);
        if (!ok) begin
            m_ferr = 1'b1;
        end else if (mq.size() < MDEPTH) begin
            mq.push_back(b);
        end else if (pop_same) begin
            void'(mq.pop_front());
            mq.push_back(b);
        end else begin
            m_ovr = 1'b1;
        end
    endfunction

    function automatic void model_ctrl(input logic [1:0] op);
        if (op[0] && mq.size() > 0) void'(mq.pop_front());
        if (op[1]) begin
            m_ovr  = 1'b0;
            m_ferr = 1'b0;
        end
    endfunction

    function automatic logic [63:0] exp_status();
        logic [63:0] s;
        int n;
        n     = mq.size();
        s     = '0;
        s[0]  = (n > 0);
        s[1]  = (n == MDEPTH);
        s[2]  = m_ovr;
        s[3]  = m_ferr;
        s[11:8] = 4'(n);
        return s;
    endfunction

    task automatic check_all(input string tag);
        logic [63:0] d;
        rd(A_STAT, d);
        chk({tag, "/status"}, d, exp_status());
        rd(A_DATA, d);
        chk({tag, "/rxdata"}, d, (mq.size() > 0) ? {56'h0, mq[0]} : 64'h0);
        rd(A_RSVD, d);
        chk({tag, "/rsvd"}, d, 64'h0);
        chk({tag, "/irq"}, {63'h0, irq}, {63'h0, mq.size() > 0});
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        while (mq.size() > 0) begin
            check_all(tag);
            wr(A_CTRL, 64'h1);
            model_ctrl(2'b01);
        end
        wr(A_CTRL, 64'h2);
        model_ctrl(2'b10);
        check_all({tag, "_done"});
    endtask

    initial begin
        logic [63:0] d;
        int lat;
        reset  = 1'b0;
        rx     = 1'b1;
        valid  = 1'b0;
        wvalid = 1'b0;
        addr   = '0;
        wdata  = '0;
        m_ovr  = 1'b0;
        m_ferr = 1'b0;
        cycles(3);
        for (int a = 0; a < 4; a++) begin
            rd(64'(a * 8), d);
            chk("reset_rd", d, 64'h0);
        end
        chk("reset_irq", {63'h0, irq}, 64'h0);
        reset = 1'b1;
        cycles(10);

        lat = -1;
        fork
            send_frame(8'hA5, 1'b1);
            begin
                for (int i = 1; i <= LAT + 40; i++) begin
                    @(posedge clk);
                    #1;
                    if (irq) begin
                        lat = i - 1;
                        break;
                    end
                end
            end
        join
        chk("latency", 64'(lat), 64'(LAT));
        model_frame(8'hA5, 1'b1, 1'b0);
        check_all("a5");
        wr(A_CTRL, 64'h1);
        model_ctrl(2'b01);
        check_all("a5_pop");

        rx = 1'b0;
        cycles(4);
        rx = 1'b1;
        cycles(2 * CPB);
        check_all("glitch");

        send_frame(8'h3C, 1'b0);
        model_frame(8'h3C, 1'b0, 1'b0);
        cycles(CPB);
        check_all("ferr");
        wr(A_CTRL, 64'h2);
        model_ctrl(2'b10);
        check_all("ferr_clr");

        for (int i = 1; i <= 5; i++) begin
            send_frame(8'(i), 1'b1);
            model_frame(8'(i), 1'b1, 1'b0);
        end
        check_all("five");
        drain("five_pop");

        for (int i = 0; i < MDEPTH; i++) begin
            send_frame(8'(16 + i), 1'b1);
            model_frame(8'(16 + i), 1'b1, 1'b0);
        end
        fork
            send_frame(8'h77, 1'b1);
            begin
                repeat (LAT) @(posedge clk);
                #1;
                addr   = A_CTRL;
                wdata  = 64'h1;
                valid  = 1'b1;
                wvalid = 1'b1;
                @(posedge clk);
                #1;
                valid  = 1'b0;
                wvalid = 1'b0;
            end
        join
        model_frame(8'h77, 1'b1, 1'b1);
        check_all("pop_push");
        drain("pop_push_drain");

        send_frame(8'hC3, 1'b1);
        model_frame(8'hC3, 1'b1, 1'b0);
        rx = 1'b0;
        cycles(3 * CPB);
        reset = 1'b0;
        mq.delete();
        m_ovr  = 1'b0;
        m_ferr = 1'b0;
        cycles(2);
        reset = 1'b1;
        cycles(12 * CPB);
        check_all("rst_low");
        rx = 1'b1;
        cycles(4);
        send_frame(8'h5A, 1'b1);
        model_frame(8'h5A, 1'b1, 1'b0);
        check_all("rst_5a");
        drain("rst_drain");

        for (int it = 0; it < 40; it++) begin
            logic [7:0] b;
            bit ok;
            logic [1:0] op;
            b  = 8'($urandom);
            ok = ($urandom_range(7) != 0);
            send_frame(b, ok);
            model_frame(b, ok, 1'b0);
            check_all("rand");
            if ($urandom_range(3) == 0) begin
                wr(A_DATA, 64'h3);
            end
            op = 2'($urandom_range(3));
            if (op != 2'b00) begin
                wr(A_CTRL, {62'h0, op});
                model_ctrl(op);
                check_all("rand_ctrl");
            end
            cycles(ok ? $urandom_range(3) : CPB);
        end
        drain("final");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
